mega_ram_dma: RTL and testbench

- Block-transfer engine directly upstream of the data RAM (mega_ram port: cs, we, re, a, d_in, d_out).
- Arbitrates the single RAM port between the CPU data bus and an internal copy/fill engine. The CPU always has priority.
- Performs RAM-to-RAM copy or constant fill on a start pulse.
- Honours the RAM's timing: read data is registered one clock after the address and gated combinationally by the current cycle's cs&re.

---
 rtl/mega_ram_dma.sv | 181 ++++++++++++++++++
 tb/tb_mega_ram_dma.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mega_ram_dma.sv
// Block copy/fill engine sharing the single data-RAM port with the CPU.
// The CPU always owns the port when cpu_cs is high; the engine uses the idle cycles.
module mega_ram_dma #(
  parameter int ADDR_BUS_WIDTH = 13,
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode,
  input  logic [ADDR_BUS_WIDTH-1:0] src,
  input  logic [ADDR_BUS_WIDTH-1:0] dst,
  input  logic [ADDR_BUS_WIDTH:0]   len,
  input  logic [DATA_BUS_WIDTH-1:0] fill_val,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  input  logic                      cpu_cs,
  input  logic                      cpu_we,
  input  logic                      cpu_re,
  input  logic [ADDR_BUS_WIDTH-1:0] cpu_a,
  input  logic [DATA_BUS_WIDTH-1:0] cpu_d_in,
  output logic [DATA_BUS_WIDTH-1:0] cpu_d_out,
  output logic                      ram_cs,
  output logic                      ram_we,
  output logic                      ram_re,
  output logic [ADDR_BUS_WIDTH-1:0] ram_a,
  output logic [DATA_BUS_WIDTH-1:0] ram_d_in,
  input  logic [DATA_BUS_WIDTH-1:0] ram_d_out,
  output logic [1:0]                dbg_state
);

  localparam int AW = ADDR_BUS_WIDTH;
  localparam int DW = DATA_BUS_WIDTH;
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [DW-1:0]   fill_q, fill_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            dma_cs, dma_we, dma_re;
  logic [AW-1:0]   dma_a;
  logic [DW-1:0]   dma_d;
  logic            dma_on;

  // Handshake: start is a single-cycle request honoured only in IDLE; done is
  // a single-cycle completion pulse; busy is high exactly while not in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
    dma_cs  = 1'b0;
    dma_we  = 1'b0;
    dma_re  = 1'b0;
    dma_a   = '0;
    dma_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            mode_d  = mode;
            src_d   = src;
            dst_d   = dst;
            cnt_d   = len;
            fill_d  = fill_val;
            state_d = mode ? S_WR : S_RD;
          end
        end
      end
      S_RD: begin
        dma_cs = 1'b1;
        dma_a  = src_q;
        if (!cpu_cs) state_d = S_WR;
      end
      S_WR: begin
        dma_cs = 1'b1;
        dma_we = 1'b1;
        dma_a  = dst_q;
        // Copy writes the byte the RAM returns for the previous RD cycle;
        // re must be high for the RAM to present it.
        if (mode_q) begin
          dma_d = fill_q;
        end else begin
          dma_re = 1'b1;
          dma_d  = ram_d_out;
        end
        if (!cpu_cs) begin
          src_d = src_q + PTR_ONE;
          dst_d = dst_q + PTR_ONE;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (!mode_q) begin
            state_d = S_RD;
          end
        end else if (!mode_q) begin
          // Forwarded read data was lost to the CPU cycle; fetch it again.
          state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  // Engine drive is suppressed in a reset cycle so no write lands after rst.
  assign dma_on = (state_q != S_IDLE) && !rst;

  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_a    = '0;
    ram_d_in = '0;
    if (cpu_cs) begin
      ram_cs   = 1'b1;
      ram_we   = cpu_we;
      ram_re   = cpu_re;
      ram_a    = cpu_a;
      ram_d_in = cpu_d_in;
    end else if (dma_on) begin
      ram_cs   = dma_cs;
      ram_we   = dma_we;
      ram_re   = dma_re;
      ram_a    = dma_a;
      ram_d_in = dma_d;
    end
  end

  assign cpu_d_out = cpu_cs ? ram_d_out : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mega_ram_dma.sv
// Bench for mega_ram_dma: behavioural RAM, transfer-level memory model,
// directed scenarios followed by randomized copies and fills.
module tb_mega_ram_dma;

  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 8192;

  logic          clk;
  logic          rst;
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len;
  logic [DW-1:0] fill_val;
  logic          abort;
  logic          busy;
  logic          done;
  logic          cpu_cs, cpu_we, cpu_re;
  logic [AW-1:0] cpu_a;
  logic [DW-1:0] cpu_d_in;
  logic [DW-1:0] cpu_d_out;
  logic          ram_cs, ram_we, ram_re;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d_in;
  logic [DW-1:0] ram_d_out;
  logic [1:0]    dbg_state;

  mega_ram_dma #(.ADDR_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .abort(abort), .busy(busy), .done(done),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_a(cpu_a),
    .cpu_d_in(cpu_d_in), .cpu_d_out(cpu_d_out), .ram_cs(ram_cs),
    .ram_we(ram_we), .ram_re(ram_re), .ram_a(ram_a), .ram_d_in(ram_d_in),
    .ram_d_out(ram_d_out), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: read data registered one clock after the address, gated by cs&re.
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] rdata_q;
  always @(posedge clk) begin
    if (ram_cs) begin
      rdata_q <= mem[ram_a];
      if (ram_we) mem[ram_a] <= ram_d_in;
    end
  end
  assign ram_d_out = (ram_cs && ram_re) ? rdata_q : '0;

  int dma_wr_cnt = 0;
  always @(posedge clk) begin
    if (ram_cs && ram_we && !cpu_cs) dma_wr_cnt <= dma_wr_cnt + 1;
  end

  // scoreboard
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] ref_mem [0:DEPTH-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Element i of a transfer completes before element i+1, so overlapping
  // copies naturally propagate already-written bytes.
  task automatic model_xfer(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input int n, input logic [DW-1:0] f);
    for (int i = 0; i < n; i++) begin
      int sa, da;
      sa = (int'(s) + i) % DEPTH;
      da = (int'(d) + i) % DEPTH;
      ref_mem[da] = m ? f : ref_mem[sa];
    end
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  // driver tasks
  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_re = 1'b0; cpu_a = a; cpu_d_in = d;
    @(negedge clk);
    cpu_cs = 1'b0; cpu_we = 1'b0;
    ref_mem[a] = d;
  endtask

  int            cfg_abort_at, cfg_rst_at, cfg_inj_at, cfg_cpu_at;
  bit            cfg_cpu_rand;
  logic [AW-1:0] cfg_cpu_addr;
  int            r_lat, r_busy, r_wr, r_both;
  logic [DW-1:0] r_cpu_rd;
  logic [AW-1:0] r_ram_a;

  task automatic clear_cfg();
    cfg_abort_at = 0; cfg_rst_at = 0; cfg_inj_at = 0; cfg_cpu_at = 0;
    cfg_cpu_rand = 1'b0; cfg_cpu_addr = '0;
  endtask

  // Start is driven in cycle 0; r_lat is the cycle in which done is seen,
  // or 0 if the engine went idle without a done pulse.
  task automatic run_xfer(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW:0] n, input logic [DW-1:0] f, input string tag);
    int w0;
    bit ended;
    w0 = dma_wr_cnt; r_lat = 0; r_busy = 0; r_both = 0; ended = 1'b0;
    r_cpu_rd = '0; r_ram_a = '0;
    mode = m; src = s; dst = d; len = n; fill_val = f; start = 1'b1;
    for (int k = 1; k <= 20000 && !ended; k++) begin
      @(negedge clk);
      if (busy) r_busy++;
      if (busy && done) r_both++;
      start = 1'b0; abort = 1'b0; rst = 1'b0; cpu_cs = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0;
      if (done) begin
        r_lat = k; ended = 1'b1;
      end else if (!busy && k > 1) begin
        ended = 1'b1;
      end
      if (!ended) begin
        if (k == cfg_abort_at) abort = 1'b1;
        if (k == cfg_rst_at) rst = 1'b1;
        if (k == cfg_inj_at) begin
          start = 1'b1; mode = ~m; src = AW'($urandom); dst = AW'($urandom); len = 14'd5;
        end
        if (cfg_cpu_rand && $urandom_range(0, 2) == 0) begin
          cpu_cs = 1'b1; cpu_re = 1'b1; cpu_a = AW'($urandom);
        end
        if (cfg_cpu_at != 0 && (k == cfg_cpu_at || k == cfg_cpu_at + 1)) begin
          cpu_cs = 1'b1; cpu_re = 1'b1; cpu_a = cfg_cpu_addr;
          #1;
          if (k == cfg_cpu_at) r_ram_a = ram_a;
          else r_cpu_rd = cpu_d_out;
        end
      end
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0; cpu_cs = 1'b0; cpu_re = 1'b0;
    chk({tag, "_terminated"}, ended, 1);
    r_wr = dma_wr_cnt - w0;
  endtask

  initial begin
    logic          rm;
    logic [AW-1:0] rs, rd;
    int            rn;
    logic [DW-1:0] rf;

    clear_cfg();
    rst = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
    fill_val = '0; abort = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0;
    cpu_a = '0; cpu_d_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_ram_strobes", {ram_cs, ram_we, ram_re}, 0);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_d_in", ram_d_in, 0);
    chk("rst_cpu_d_out", cpu_d_out, 0);

    // CPU passes straight through while the engine is idle
    cpu_cs = 1'b1; cpu_re = 1'b1; cpu_a = 13'h0AB; cpu_d_in = 8'h77;
    #1;
    chk("mux_cpu_strobes", {ram_cs, ram_we, ram_re}, 3'b101);
    chk("mux_cpu_a", ram_a, 13'h0AB);
    chk("mux_cpu_d_in", ram_d_in, 8'h77);
    @(negedge clk);
    cpu_cs = 1'b0; cpu_re = 1'b0;

    // full-depth fill, len = 2**AW
    run_xfer(1'b1, 13'h0123, 13'h0123, 14'h2000, 8'h3C, "fill_full");
    model_xfer(1'b1, 13'h0123, 13'h0123, DEPTH, 8'h3C);
    chk("fill_full_lat", r_lat, DEPTH + 1);
    chk("fill_full_busy", r_busy, DEPTH);
    chk("fill_full_wr", r_wr, DEPTH);
    check_mem("fill_full_mem");

    // fill 4 at 0x100
    run_xfer(1'b1, 13'h0, 13'h100, 14'd4, 8'hA5, "fill4");
    model_xfer(1'b1, 13'h0, 13'h100, 4, 8'hA5);
    chk("fill4_lat", r_lat, 5);
    chk("fill4_busy", r_busy, 4);
    chk("fill4_wr", r_wr, 4);
    chk("fill4_untouched", mem[13'h104], 8'h3C);
    check_mem("fill4_mem");

    // copy 3 from 0x20 to 0x40
    cpu_write(13'h20, 8'd11);
    cpu_write(13'h21, 8'd22);
    cpu_write(13'h22, 8'd33);
    run_xfer(1'b0, 13'h20, 13'h40, 14'd3, 8'h00, "copy3");
    model_xfer(1'b0, 13'h20, 13'h40, 3, 8'h00);
    chk("copy3_lat", r_lat, 7);
    chk("copy3_busy", r_busy, 6);
    chk("copy3_wr", r_wr, 3);
    chk("copy3_both", r_both, 0);
    check_mem("copy3_mem");

    // CPU read held for two cycles starting in element 1's WR cycle (cycle 4):
    // the lost write costs an RD+WR, the stalled RD one more cycle.
    cpu_write(13'h300, 8'h5C);
    cfg_cpu_at = 4; cfg_cpu_addr = 13'h300;
    run_xfer(1'b0, 13'h20, 13'h60, 14'd3, 8'h00, "preempt");
    clear_cfg();
    model_xfer(1'b0, 13'h20, 13'h60, 3, 8'h00);
    chk("preempt_ram_a", r_ram_a, 13'h300);
    chk("preempt_cpu_rd", r_cpu_rd, 8'h5C);
    chk("preempt_lat", r_lat, 7 + 3);
    chk("preempt_wr", r_wr, 3);
    check_mem("preempt_mem");

    // wrap-around fill
    run_xfer(1'b1, 13'h0, 13'h1FFE, 14'd4, 8'hE1, "wrap");
    model_xfer(1'b1, 13'h0, 13'h1FFE, 4, 8'hE1);
    chk("wrap_lat", r_lat, 5);
    chk("wrap_a0", mem[13'h0000], 8'hE1);
    chk("wrap_a1", mem[13'h0001], 8'hE1);
    chk("wrap_a2", mem[13'h0002], 8'h3C);
    check_mem("wrap_mem");

    // zero-length start
    run_xfer(1'b1, 13'h0, 13'h500, 14'd0, 8'hFF, "len0");
    chk("len0_lat", r_lat, 1);
    chk("len0_busy", r_busy, 0);
    chk("len0_wr", r_wr, 0);
    check_mem("len0_mem");

    // start while busy is ignored
    cfg_inj_at = 2;
    run_xfer(1'b1, 13'h0, 13'h700, 14'd10, 8'h4D, "inject");
    clear_cfg();
    model_xfer(1'b1, 13'h0, 13'h700, 10, 8'h4D);
    chk("inject_lat", r_lat, 11);
    chk("inject_wr", r_wr, 10);
    check_mem("inject_mem");

    // abort during the second write of an 8-element fill
    cfg_abort_at = 2;
    run_xfer(1'b1, 13'h0, 13'h800, 14'd8, 8'h99, "abort");
    clear_cfg();
    model_xfer(1'b1, 13'h0, 13'h800, 2, 8'h99);
    chk("abort_no_done", r_lat, 0);
    chk("abort_busy", r_busy, 2);
    chk("abort_wr", r_wr, 2);
    check_mem("abort_mem");

    // reset in the third WR cycle: only two writes land
    cfg_rst_at = 3;
    run_xfer(1'b1, 13'h0, 13'h900, 14'd8, 8'h77, "rstmid");
    clear_cfg();
    model_xfer(1'b1, 13'h0, 13'h900, 2, 8'h77);
    chk("rstmid_no_done", r_lat, 0);
    chk("rstmid_busy", r_busy, 3);
    chk("rstmid_wr", r_wr, 2);
    chk("rstmid_state", dbg_state, 0);
    check_mem("rstmid_mem");
    run_xfer(1'b0, 13'h900, 13'h910, 14'd4, 8'h00, "after_rst");
    model_xfer(1'b0, 13'h900, 13'h910, 4, 8'h00);
    chk("after_rst_lat", r_lat, 9);
    check_mem("after_rst_mem");

    // overlapping copy, dst = src + 1
    for (int j = 0; j < 4; j++) cpu_write(AW'(13'hA00 + j), DW'($urandom));
    run_xfer(1'b0, 13'hA00, 13'hA01, 14'd4, 8'h00, "overlap");
    model_xfer(1'b0, 13'hA00, 13'hA01, 4, 8'h00);
    chk("overlap_lat", r_lat, 9);
    check_mem("overlap_mem");

    // randomized transfers; odd iterations add random CPU reads
    for (int it = 0; it < 12; it++) begin
      rm = 1'($urandom_range(0, 1));
      rs = AW'($urandom);
      rd = AW'($urandom);
      rn = $urandom_range(1, 24);
      rf = DW'($urandom);
      if (!rm) for (int j = 0; j < rn; j++) cpu_write(AW'(int'(rs) + j), DW'($urandom));
      cfg_cpu_rand = it[0];
      run_xfer(rm, rs, rd, 14'(rn), rf, $sformatf("rand%0d", it));
      clear_cfg();
      model_xfer(rm, rs, rd, rn, rf);
      if (it[0]) chk($sformatf("rand%0d_done", it), (r_lat > 0), 1);
      else chk($sformatf("rand%0d_lat", it), r_lat, rm ? rn + 1 : 2 * rn + 1);
      chk($sformatf("rand%0d_wr", it), r_wr, rn);
      chk($sformatf("rand%0d_both", it), r_both, 0);
      check_mem($sformatf("rand%0d_mem", it));
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
